// File: rtl/encoder_rr_queue.sv
// ============================================================================
// Module   : encoder_rr_queue
// Purpose  : Serialises multi-hot request lines into binary addresses, one
//            per valid/ready handshake. Round-robin arbitration is enabled by
//            defining ENCODER_ROUND_ROBIN_EN; otherwise fixed lowest-first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder_rr_queue #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2**N-1:0]   data_in,
    input  logic              en_in,
    output logic [N-1:0]      address_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [N:0]        pending_count,
    output logic              merge_out
);

    localparam int c_width = 2**N;

    logic [c_width-1:0] r_pending_q;
    logic [c_width-1:0] w_pending_d;
    logic [N-1:0]       r_addr_q;
    logic [N-1:0]       w_addr_d;
    logic               r_valid_q;
    logic               w_valid_d;
    logic [N:0]         r_count_q;
    logic [N:0]         w_count_d;
    logic               r_merge_q;
    logic               w_merge_d;

    logic               w_slot_free;
    logic               w_grant;
    logic [N-1:0]       w_sel;
    logic [c_width-1:0] w_sel_mask;
    logic [c_width-1:0] w_capture;

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [N-1:0]       r_ptr_q;
    logic [N-1:0]       w_ptr_d;
    logic [N-1:0]       w_idx;

    // Scanning offsets downward leaves the smallest offset from ptr in w_sel.
    always_comb begin
        w_sel = '0;
        w_idx = '0;
        for (int i = c_width - 1; i >= 0; i--) begin
            w_idx = r_ptr_q + N'(i);
            if (r_pending_q[w_idx]) begin
                w_sel = w_idx;
            end
        end
    end
`else
    always_comb begin
        w_sel = '0;
        for (int i = c_width - 1; i >= 0; i--) begin
            if (r_pending_q[i]) begin
                w_sel = N'(i);
            end
        end
    end
`endif

    always_comb begin
        w_slot_free = !r_valid_q || ready_in;
        w_grant     = w_slot_free && (|r_pending_q);
        w_sel_mask  = w_grant ? (c_width'(1) << w_sel) : '0;
        w_capture   = en_in ? data_in : '0;

        // A bit being granted and re-requested on the same edge stays pending.
        w_pending_d = (r_pending_q & ~w_sel_mask) | w_capture;
        w_merge_d   = |(w_capture & r_pending_q & ~w_sel_mask);

        w_count_d = '0;
        for (int i = 0; i < c_width; i++) begin
            w_count_d = w_count_d + (N+1)'(w_pending_d[i]);
        end

        w_addr_d  = r_addr_q;
        w_valid_d = r_valid_q;
        if (w_grant) begin
            w_addr_d  = w_sel;
            w_valid_d = 1'b1;
        end else if (w_slot_free) begin
            w_valid_d = 1'b0;
        end
    end

`ifdef ENCODER_ROUND_ROBIN_EN
    always_comb begin
        w_ptr_d = w_grant ? (w_sel + N'(1)) : r_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending_q <= '0;
            r_addr_q    <= '0;
            r_valid_q   <= 1'b0;
            r_count_q   <= '0;
            r_merge_q   <= 1'b0;
        end else begin
            r_pending_q <= w_pending_d;
            r_addr_q    <= w_addr_d;
            r_valid_q   <= w_valid_d;
            r_count_q   <= w_count_d;
            r_merge_q   <= w_merge_d;
        end
    end

    assign address_out   = r_addr_q;
    assign valid_out     = r_valid_q;
    assign pending_count = r_count_q;
    assign merge_out     = r_merge_q;

endmodule

`default_nettype wire

// File: tb/tb_encoder_rr_queue.sv
// ============================================================================
// Module   : tb_encoder_rr_queue
// Purpose  : Self-checking bench for encoder_rr_queue: directed scenarios with
//            literal expectations plus a randomized run against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_encoder_rr_queue;

    localparam int N = 4;
    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic [W-1:0]  data_in;
    logic          en_in;
    logic [N-1:0]  address_out;
    logic          valid_out;
    logic          ready_in;
    logic [N:0]    pending_count;
    logic          merge_out;

    int n_cmp = 0;
    int n_err = 0;

    encoder_rr_queue #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .en_in        (en_in),
        .address_out  (address_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .pending_count(pending_count),
        .merge_out    (merge_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ENCODER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Behavioural model: pending set as a plain bit array, grant chosen by
    // scanning addresses in arbitration order.
    bit [W-1:0] m_pend;
    int         m_ptr;
    bit         m_valid;
    int         m_addr;
    int         m_cnt;
    bit         m_merge;
    bit         m_live = 1'b0;

    always @(posedge clk) begin
        bit [W-1:0] pre;
        bit         slot;
        bit         granted;
        bit         found;
        int         sel;
        int         base;
        int         a;
        if (rst) begin
            m_pend = '0; m_ptr = 0; m_valid = 0; m_addr = 0; m_cnt = 0;
            m_merge = 0; m_live = 1'b1;
        end else if (m_live) begin
            pre     = m_pend;
            slot    = !m_valid || ready_in;
            granted = 0;
            sel     = 0;
            base    = RR ? m_ptr : 0;
            if (slot && pre != 0) begin
                found = 0;
                for (int off = 0; off < W; off++) begin
                    a = (base + off) % W;
                    if (!found && pre[a]) begin
                        sel   = a;
                        found = 1;
                    end
                end
                granted = 1;
            end
            m_pend = pre;
            if (granted) m_pend[sel] = 1'b0;
            m_merge = 0;
            if (en_in) begin
                for (int i = 0; i < W; i++) begin
                    if (data_in[i] && pre[i] && !(granted && i == sel)) m_merge = 1;
                end
                m_pend = m_pend | data_in;
            end
            if (granted) begin
                m_addr  = sel;
                m_valid = 1;
                m_ptr   = (sel + 1) % W;
            end else if (slot) begin
                m_valid = 0;
            end
            m_cnt = $countones(m_pend);
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            n_cmp++;
            if (address_out !== N'(m_addr) || valid_out !== m_valid ||
                pending_count !== (N+1)'(m_cnt) || merge_out !== m_merge) begin
                n_err++;
                $display("FAIL model t=%0t: got addr=%0d valid=%0b cnt=%0d merge=%0b, want addr=%0d valid=%0b cnt=%0d merge=%0b",
                         $time, address_out, valid_out, pending_count, merge_out,
                         m_addr, m_valid, m_cnt, m_merge);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input int addr, input int vld,
                           input int cnt, input int mrg);
        chk({name, ".addr"},  int'(address_out),   addr);
        chk({name, ".valid"}, int'(valid_out),     vld);
        chk({name, ".count"}, int'(pending_count), cnt);
        chk({name, ".merge"}, int'(merge_out),     mrg);
    endtask

    initial begin
        rst = 1'b1; en_in = 1'b1; data_in = '0; ready_in = 1'b1;
        cyc();
        chk_out("reset", 0, 0, 0, 0);
        rst = 1'b0;
        cyc();
        chk_out("t1_empty", 0, 0, 0, 0);

        // Two requests drain in address order.
        data_in = 16'h0014; en_in = 1'b1;
        cyc();
        en_in = 1'b0; data_in = '0;
        chk_out("t2_cap", 0, 0, 2, 0);
        cyc(); chk_out("t2_g0", 2, 1, 1, 0);
        cyc(); chk_out("t2_g1", 4, 1, 0, 0);
        cyc(); chk_out("t2_idle", 4, 0, 0, 0);

        // Re-request of the bit being granted keeps it pending.
        en_in = 1'b1; data_in = 16'h0003;
        cyc(); chk_out("t3_cap", 4, 0, 2, 0);
        data_in = 16'h0001;
        cyc(); chk_out("t3_g0", 0, 1, 2, 0);
        en_in = 1'b0; data_in = '0;
        cyc(); chk_out("t3_g1", RR ? 1 : 0, 1, 1, 0);
        cyc(); chk_out("t3_g2", RR ? 0 : 1, 1, 0, 0);
        cyc(); chk("t3_idle.valid", int'(valid_out), 0);

        // Back-pressure holds the grant and the pending set.
        ready_in = 1'b0; en_in = 1'b1; data_in = 16'h0880;
        cyc(); en_in = 1'b0; data_in = '0;
        chk_out("t4_cap", RR ? 0 : 1, 0, 2, 0);
        cyc(); chk_out("t4_g", 7, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(); chk_out("t4_hold", 7, 1, 1, 0);
        end
        ready_in = 1'b1;
        cyc(); chk_out("t4_next", 11, 1, 0, 0);
        cyc(); chk("t4_idle.valid", int'(valid_out), 0);

        // Merge of an already-pending bit that is not being granted.
        ready_in = 1'b0; en_in = 1'b1; data_in = 16'h0009;
        cyc(); en_in = 1'b0; data_in = '0;
        cyc(); chk_out("t5_g", 0, 1, 1, 0);
        en_in = 1'b1; data_in = 16'h0008;
        cyc(); en_in = 1'b0; data_in = '0;
        chk_out("t5_merge", 0, 1, 1, 1);
        cyc(); chk_out("t5_after", 0, 1, 1, 0);
        ready_in = 1'b1;
        cyc(); chk_out("t5_drain", 3, 1, 0, 0);
        cyc(); chk("t5_idle.valid", int'(valid_out), 0);

        // All bits set, then reset mid-drain.
        rst = 1'b1; cyc(); rst = 1'b0;
        en_in = 1'b1; data_in = 16'hFFFF;
        cyc(); en_in = 1'b0; data_in = '0;
        chk_out("t6_cap", 0, 0, 16, 0);
        for (int i = 0; i <= 5; i++) begin
            cyc(); chk_out("t6_g", i, 1, 15 - i, 0);
        end
        rst = 1'b1; en_in = 1'b1; data_in = 16'h0100;
        cyc(); rst = 1'b0; en_in = 1'b0; data_in = '0;
        chk_out("t6_rst", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); chk_out("t6_quiet", 0, 0, 0, 0);
        end

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            ready_in = ($urandom_range(0, 3) != 0);
            en_in    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) data_in = 16'hFFFF;
            else data_in = 16'($urandom & $urandom & $urandom);
            cyc();
        end
        rst = 1'b0; en_in = 1'b0; ready_in = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
